// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx arbiter slice.
// Arbiter states, the default byte width and the parity-type encodings.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set request at or after rr_ptr_i, wrapping at NUM_REQ.
// Purely combinational; no backpressure of its own.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Explicit wrap so a non-power-of-2 NUM_REQ never indexes an absent requester.
            sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx among NUM_REQ producers; ack/DATA_VALID 2 clk after req.
// Requesters hold req until ack; a grant is only issued while uart_tx reports !Busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = UART_DATA_W,
    parameter int BUSY_TMO = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_par_en,
    input  logic [NUM_REQ-1:0]          req_par_typ,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        DATA_VALID,
    output logic [DATA_W-1:0]           P_DATA,
    output logic                        PAR_EN,
    output logic                        PAR_TYP,
    input  logic                        Busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        tmo_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                dv_q, dv_d;
    logic [DATA_W-1:0]   pdata_q, pdata_d;
    logic                par_en_q, par_en_d;
    logic                par_typ_q, par_typ_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                tmo_err_q, tmo_err_d;

    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    next_ptr;
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_vld),
        .idx_o    (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign next_ptr = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        ack_d     = '0;
        dv_d      = 1'b0;
        pdata_d   = pdata_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        grant_d   = grant_q;
        tmo_err_d = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Busy here means a frame we did not start; hold off until it ends.
                if (pick_vld && !Busy) begin
                    pdata_d   = data_arr[pick_idx];
                    par_en_d  = req_par_en[pick_idx];
                    par_typ_d = req_par_typ[pick_idx];
                    grant_d   = pick_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                dv_d           = 1'b1;
                ack_d[grant_q] = 1'b1;
                tmo_cnt_d      = '0;
                state_d        = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (Busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == CNT_W'(BUSY_TMO-1)) begin
                    tmo_err_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ARB_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!Busy) begin
                    rr_ptr_d = next_ptr;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
            ack_q     <= '0;
            dv_q      <= 1'b0;
            pdata_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            grant_q   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
            ack_q     <= ack_d;
            dv_q      <= dv_d;
            pdata_q   <= pdata_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            grant_q   <= grant_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign ack        = ack_q;
    assign DATA_VALID = dv_q;
    assign P_DATA     = pdata_q;
    assign PAR_EN     = par_en_q;
    assign PAR_TYP    = par_typ_q;
    assign grant_id   = grant_q;
    assign tmo_err    = tmo_err_q;

endmodule
